// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop input synchroniser, feeding a small
// circular FIFO that the CSR block drains one byte per read strobe.
module uart_rx_fifo #(
  parameter int CLOCK_RATE = 24_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rd,
  input  logic               clear_err,
  output logic [7:0]         rdata,
  output logic               valid,
  output logic [FIFO_AW:0]   count,
  output logic               overrun,
  output logic               frame_err
);

  localparam int DATA_W  = 8;
  localparam int DIVISOR = CLOCK_RATE / BAUD_RATE;
  localparam int TW      = $clog2(DIVISOR);
  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam logic [TW-1:0]    T_HALF = TW'(DIVISOR / 2 - 1);
  localparam logic [TW-1:0]    T_FULL = TW'(DIVISOR - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } state_t;

  // Stage p0/p1: synchroniser, idles high so reset never looks like a start bit
  logic rx_p0, rx_p1, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  state_t              state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                push, fe_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    fe_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          timer_n = T_HALF;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (timer == '0) begin
          if (!rx_s) begin
            timer_n   = T_FULL;
            bit_idx_n = '0;
            state_n   = ST_DATA;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_DATA: begin
        if (timer == '0) begin
          shreg_n   = {rx_s, shreg[DATA_W-1:1]};
          timer_n   = T_FULL;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = ST_STOP;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_STOP: begin
        if (timer == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = ST_BREAK;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FIFO: a push into a full FIFO is only accepted when a pop frees the slot
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr, rptr_nx;
  logic               pop, full, wr_en, ovr_set;

  assign valid   = (count != '0);
  assign full    = (count == CNT_FULL);
  assign pop     = rd & valid;
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;
  assign rptr_nx = rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr_nx;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Head register tracks the entry that will sit at rptr next cycle
      if (pop) begin
        if (count == CNT_ONE) begin
          if (wr_en) rdata <= shreg;
        end else begin
          rdata <= mem[rptr_nx];
        end
      end else if (wr_en && count == '0) begin
        rdata <= shreg;
      end
      if (ovr_set)        overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
      if (fe_set)         frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: DIVISOR=16, depth 4; a queue holds the bytes the
// line driver sent and is compared against rdata as each entry is popped.
module tb_uart_rx_fifo;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int BIT   = 16;

  logic          clk = 1'b0;
  logic          rst, rx, rd, clear_err;
  logic [7:0]    rdata;
  logic          valid;
  logic [AW:0]   count;
  logic          overrun, frame_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.CLOCK_RATE(16), .BAUD_RATE(1), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd(rd), .clear_err(clear_err),
    .rdata(rdata), .valid(valid), .count(count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Every task below starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] data, input bit accept);
    if (accept) exp_q.push_back(data);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      idle(BIT);
    end
    rx = 1'b1;
    idle(BIT);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check({tag, "_valid"}, valid, 1'b1);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata, e);
    end
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic clr_pulse();
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rd = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ovr", overrun, 0);
    check("rst_fe", frame_err, 0);
    rst = 1'b0;
    idle(5);

    // Single byte with exact push latency
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("t1_valid_before", valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_valid_after", valid, 1);
      end
    join
    @(negedge clk);
    check("t1_count", count, 1);
    idle(1);
    pop_chk("t1");
    @(negedge clk);
    check("t1_empty_valid", valid, 0);
    check("t1_empty_count", count, 0);
    idle(1);

    // Back-to-back frames
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(4);
    @(negedge clk);
    check("t2_count", count, 3);
    check("t2_ovr", overrun, 0);
    check("t2_fe", frame_err, 0);
    idle(1);
    for (int i = 0; i < 3; i++) pop_chk("t2");

    // Overrun on the fifth byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i), exp_q.size() < DEPTH);
    idle(4);
    @(negedge clk);
    check("t3_count", count, 4);
    check("t3_ovr", overrun, 1);
    idle(1);
    for (int i = 0; i < 4; i++) pop_chk("t3");
    clr_pulse();
    @(negedge clk);
    check("t3_ovr_clr", overrun, 0);
    check("t3_count_end", count, 0);
    idle(1);

    // Push and pop on the same cycle while full
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rd = 1'b1;
        @(negedge clk);
        check("t4_pop_rdata", rdata, exp_q.pop_front());
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    @(negedge clk);
    check("t4_count", count, 4);
    check("t4_ovr", overrun, 0);
    idle(1);
    for (int i = 0; i < 4; i++) pop_chk("t4");

    // Glitch, held-low break, then recovery
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    @(negedge clk);
    check("t5_glitch_valid", valid, 0);
    check("t5_glitch_fe", frame_err, 0);
    idle(1);
    rx = 1'b0;
    idle(200);
    @(negedge clk);
    check("t5_break_fe", frame_err, 1);
    check("t5_break_count", count, 0);
    idle(1);
    clr_pulse();
    idle(118);
    @(negedge clk);
    check("t5_break_once", frame_err, 0);
    idle(1);
    rx = 1'b1;
    idle(2 * BIT);
    send_byte(8'h7E, 1'b1);
    idle(2);
    @(negedge clk);
    check("t5_count", count, 1);
    idle(1);
    pop_chk("t5");

    // Asynchronous reset mid-frame with bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    fork
      send_byte(8'hFF, 1'b0);
      begin
        repeat (40) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_valid", valid, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_ovr", overrun, 0);
        check("t6_rst_fe", frame_err, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(2 * BIT);
    @(negedge clk);
    check("t6_idle_count", count, 0);
    idle(1);
    send_byte(8'h42, 1'b1);
    idle(2);
    pop_chk("t6");
    @(negedge clk);
    check("t6_end_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
